// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch front end feeding the decode stage. Owns the fetch PC,
// issues single-outstanding requests to instruction memory over a req/ack
// handshake, buffers returned instructions (with their PCs) in a small
// prefetch FIFO, and presents the FIFO head to decode over valid/ready.
// A redirect pulse flushes the FIFO and restarts fetch at a new PC.
//
// Parameters:
//   PC_W     fetch address width (PC wraps modulo 2**PC_W)
//   INSTR_W  instruction width
//   DEPTH    prefetch FIFO entries (power of two, >= 2)
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   imem_req     out  fetch request (registered)
//   imem_addr    out  fetch address, stable while imem_req=1
//   imem_ack     in   memory data return, only meaningful with imem_req=1
//   imem_rdata   in   returned instruction, valid with imem_ack
//   redirect     in   one-cycle flush/restart pulse
//   redirect_pc  in   new fetch PC, valid with redirect
//   id_valid     out  FIFO head valid
//   id_ready     in   decode accepts the head
//   id_instr     out  FIFO head instruction
//   id_pc        out  PC of the FIFO head
//   queue_count  out  occupied FIFO entries
//   fetch_halted out  fetch stopped on an all-zero instruction
//
// Build option:
//   FETCH_ZERO_HALT_EN  when defined, an all-zero instruction is enqueued and
//                       then fetch stops until redirect or reset. When not
//                       defined, zero instructions are ordinary and
//                       fetch_halted is tied to 0.
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [PC_W-1:0]          imem_addr,
  input  logic                     imem_ack,
  input  logic [INSTR_W-1:0]       imem_rdata,
  input  logic                     redirect,
  input  logic [PC_W-1:0]          redirect_pc,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [INSTR_W-1:0]       id_instr,
  output logic [PC_W-1:0]          id_pc,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     fetch_halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_e;

  // Control state
  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   addr_q, addr_d;
  logic              req_q, req_d;
  logic              halt_q, halt_d;

  // FIFO state
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [PC_W-1:0]    pc_mem_q    [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic               enq, deq, halting;
  logic [CNT_W-1:0]   count_post;

  // Data is only taken in REQ; an ack in DISCARD belongs to a request that
  // predates the last redirect, and an ack coinciding with redirect is dropped.
  assign enq = (state_q == REQ) && imem_ack && !redirect;
  assign deq = id_valid && id_ready;

  // Occupancy after this cycle's enqueue/dequeue (redirect handled separately).
  assign count_post = count_q + {{PTR_W{1'b0}}, enq} - {{PTR_W{1'b0}}, deq};

`ifdef FETCH_ZERO_HALT_EN
  assign halting = enq && (imem_rdata == '0);
`else
  assign halting = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d = state_q;
    pc_d    = pc_q;
    halt_d  = halt_q || halting;

    unique case (state_q)
      IDLE: begin
        // Uses post-dequeue occupancy so fetch resumes the cycle after a
        // dequeue frees a slot in a full FIFO.
        if (!halt_q && (count_post < DEPTH_C)) state_d = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          pc_d = pc_q + PC_W'(1);
          if ((count_post < DEPTH_C) && !halting) state_d = REQ;
          else                                    state_d = IDLE;
        end
      end
      DISCARD: begin
        // Stale data is dropped; pc_q already holds the redirected PC.
        if (imem_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      pc_d   = redirect_pc;
      halt_d = 1'b0;
      // An unacked request must still complete before the new PC is issued.
      if ((state_q != IDLE) && !imem_ack) state_d = DISCARD;
      else                                state_d = REQ;
    end

    req_d  = (state_d != IDLE);
    // DISCARD keeps the old address on the bus until its ack arrives.
    addr_d = (state_d == REQ) ? pc_d : addr_q;
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      halt_q  <= halt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Prefetch FIFO
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is reset here because the head entry is visible on
  // id_instr/id_pc and must read as zero out of reset; storage without such a
  // visibility requirement would normally be left unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) begin
        instr_mem_q[wr_ptr_q] <= imem_rdata;
        pc_mem_q[wr_ptr_q]    <= pc_q;
        wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
      end
      if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_post;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign id_valid    = (count_q != '0);
  assign id_instr    = instr_mem_q[rd_ptr_q];
  assign id_pc       = pc_mem_q[rd_ptr_q];
  assign queue_count = count_q;

`ifdef FETCH_ZERO_HALT_EN
  assign fetch_halted = halt_q;
`else
  assign fetch_halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed bench for fetch_queue. A small instruction-memory responder acks
// imem_req after a programmable number of wait cycles (0 = same-cycle ack).
// Each scenario task resets the DUT, drives stimulus and compares outputs
// against hand-computed values. Inputs change and outputs are sampled 1 time
// unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [3:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [3:0]  redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_instr;
  logic [3:0]  id_pc;
  logic [2:0]  queue_count;
  logic        fetch_halted;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_queue #(.PC_W(4), .INSTR_W(16), .DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .queue_count  (queue_count),
    .fetch_halted (fetch_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Instruction memory responder
  // ---------------------------------------------------------------------------
  logic [15:0] mem [16];
  int lat;
  int wait_cnt;

  assign imem_ack   = imem_req && (wait_cnt >= lat);
  assign imem_rdata = mem[imem_addr];

  always @(posedge clk or negedge reset) begin
    if (!reset)                      wait_cnt <= 0;
    else if (imem_req && !imem_ack)  wait_cnt <= wait_cnt + 1;
    else                             wait_cnt <= 0;
  end

  // Expected memory contents (identical table the responder is loaded from).
  function automatic logic [15:0] exp_mem(input int a);
    case (a)
      0: return 16'h1123;
      1: return 16'h2412;
      2: return 16'h3502;
      3: return 16'h4651;
      4: return 16'h0000;
      default: return 16'hA000 | 16'(a);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first cycle after reset release (FSM in IDLE).
  task automatic do_reset();
    redirect    = 1'b0;
    redirect_pc = 4'd0;
    id_ready    = 1'b0;
    reset       = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    lat = 100;
    redirect = 1'b0; redirect_pc = 4'd0; id_ready = 1'b0;
    reset = 1'b0;
    tick();
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_tests++; if (imem_addr !== 4'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", imem_addr); end
    n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", id_valid); end
    n_tests++; if (id_instr !== 16'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0000", id_instr); end
    n_tests++; if (id_pc !== 4'd0) begin n_fail++; $display("FAIL reset_pc: got %0d expected 0", id_pc); end
    n_tests++; if (queue_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", queue_count); end
    n_tests++; if (fetch_halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", fetch_halted); end
    reset = 1'b1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_idle_req: got %b expected 0", imem_req); end
    tick();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 4'd0) begin
      n_fail++; $display("FAIL first_req: got req=%b addr=%0d expected req=1 addr=0", imem_req, imem_addr);
    end
    // Asynchronous reset abandons the pending request without a clock edge.
    tick();
    reset = 1'b0;
    #1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL async_reset_req: got %b expected 0", imem_req); end
    reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stream();
    lat = 0;
    do_reset();
    id_ready = 1'b1;
    tick(); // first request, acked in the same cycle
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (id_valid !== 1'b1 || id_instr !== exp_mem(i) || id_pc !== 4'(i)) begin
        n_fail++;
        $display("FAIL stream[%0d]: got v=%b instr=%h pc=%0d expected v=1 instr=%h pc=%0d",
                 i, id_valid, id_instr, id_pc, exp_mem(i), i);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    logic [3:0] seen [$];
    lat = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick();
      if (imem_req && imem_ack) seen.push_back(imem_addr);
    end
    n_tests++; if (seen.size() != 4) begin n_fail++; $display("FAIL bp_req_count: got %0d expected 4", seen.size()); end
    for (int i = 0; i < seen.size() && i < 4; i++) begin
      n_tests++;
      if (seen[i] !== 4'(i)) begin n_fail++; $display("FAIL bp_addr[%0d]: got %0d expected %0d", i, seen[i], i); end
    end
    n_tests++; if (queue_count !== 3'd4) begin n_fail++; $display("FAIL bp_count_full: got %0d expected 4", queue_count); end
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_stopped: got %b expected 0", imem_req); end
    n_tests++; if (id_instr !== 16'h1123 || id_pc !== 4'd0) begin
      n_fail++; $display("FAIL bp_head: got %h/%0d expected 1123/0", id_instr, id_pc);
    end
    id_ready = 1'b1; // first dequeue at the coming edge
    tick();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 4'd4) begin
      n_fail++; $display("FAIL bp_resume: got req=%b addr=%0d expected req=1 addr=4", imem_req, imem_addr);
    end
    n_tests++; if (queue_count !== 3'd3 || id_pc !== 4'd1) begin
      n_fail++; $display("FAIL bp_after_deq: got count=%0d pc=%0d expected count=3 pc=1", queue_count, id_pc);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_redirect_discard();
    int waited;
    lat = 3;
    do_reset();
    id_ready = 1'b1;
    tick(); // req addr 0
    tick(); // first wait cycle
    tick(); // second wait cycle
    redirect = 1'b1; redirect_pc = 4'd9;
    tick();
    redirect = 1'b0;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 4'd0 || id_valid !== 1'b0) begin
      n_fail++; $display("FAIL discard_hold: got req=%b addr=%0d v=%b expected req=1 addr=0 v=0", imem_req, imem_addr, id_valid);
    end
    tick(); // stale ack was in the previous cycle
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 4'd9 || queue_count !== 3'd0) begin
      n_fail++; $display("FAIL discard_next_req: got req=%b addr=%0d count=%0d expected req=1 addr=9 count=0", imem_req, imem_addr, queue_count);
    end
    waited = 0;
    while (!id_valid && waited < 20) begin tick(); waited++; end
    n_tests++; if (id_valid !== 1'b1 || id_pc !== 4'd9 || id_instr !== exp_mem(9)) begin
      n_fail++; $display("FAIL discard_first_pc: got v=%b pc=%0d instr=%h expected v=1 pc=9 instr=%h", id_valid, id_pc, id_instr, exp_mem(9));
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_redirect_ack_full();
    int waited;
    lat = 2;
    do_reset();
    waited = 0;
    while (!(queue_count == 3'd3 && imem_req && imem_ack) && waited < 40) begin tick(); waited++; end
    n_tests++; if (waited >= 40) begin n_fail++; $display("FAIL full_setup: timeout waiting for filling ack, got count=%0d", queue_count); end
    redirect = 1'b1; redirect_pc = 4'd12;
    tick();
    redirect = 1'b0;
    n_tests++; if (queue_count !== 3'd0 || id_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_flush: got count=%0d v=%b expected count=0 v=0", queue_count, id_valid);
    end
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 4'd12) begin
      n_fail++; $display("FAIL full_new_req: got req=%b addr=%0d expected req=1 addr=12", imem_req, imem_addr);
    end
    waited = 0;
    while (!id_valid && waited < 20) begin tick(); waited++; end
    n_tests++; if (waited !== 3) begin n_fail++; $display("FAIL full_valid_delay: got %0d cycles expected 3", waited); end
    n_tests++; if (id_pc !== 4'd12 || id_instr !== exp_mem(12)) begin
      n_fail++; $display("FAIL full_first_entry: got pc=%0d instr=%h expected pc=12 instr=%h", id_pc, id_instr, exp_mem(12));
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wrap();
    logic [3:0] exp_a [4];
    exp_a[0] = 4'd14; exp_a[1] = 4'd15; exp_a[2] = 4'd0; exp_a[3] = 4'd1;
    lat = 0;
    do_reset();
    id_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 4'd14;
    for (int i = 0; i < 4; i++) begin
      tick();
      redirect = 1'b0;
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== exp_a[i]) begin
        n_fail++; $display("FAIL wrap_addr[%0d]: got req=%b addr=%0d expected req=1 addr=%0d", i, imem_req, imem_addr, exp_a[i]);
      end
      if (i > 0) begin
        n_tests++; if (id_pc !== exp_a[i-1]) begin
          n_fail++; $display("FAIL wrap_pc[%0d]: got %0d expected %0d", i-1, id_pc, exp_a[i-1]);
        end
      end
    end
    tick();
    n_tests++; if (id_pc !== 4'd1 || id_instr !== exp_mem(1)) begin
      n_fail++; $display("FAIL wrap_pc[3]: got pc=%0d instr=%h expected pc=1 instr=%h", id_pc, id_instr, exp_mem(1));
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_zero_halt();
    int waited;
    lat = 0;
    do_reset();
    id_ready = 1'b1;
    waited = 0;
    while (!(imem_req && imem_ack && imem_addr == 4'd4) && waited < 20) begin tick(); waited++; end
    n_tests++; if (waited >= 20) begin n_fail++; $display("FAIL halt_setup: timeout waiting for addr 4, got addr=%0d", imem_addr); end
    tick();
    n_tests++; if (id_valid !== 1'b1 || id_pc !== 4'd4 || id_instr !== 16'h0000) begin
      n_fail++; $display("FAIL halt_entry: got v=%b pc=%0d instr=%h expected v=1 pc=4 instr=0000", id_valid, id_pc, id_instr);
    end
`ifdef FETCH_ZERO_HALT_EN
    n_tests++; if (fetch_halted !== 1'b1 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL halt_stop: got halted=%b req=%b expected halted=1 req=0", fetch_halted, imem_req);
    end
    for (int c = 0; c < 3; c++) tick();
    n_tests++; if (imem_req !== 1'b0 || fetch_halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_stays: got req=%b halted=%b expected req=0 halted=1", imem_req, fetch_halted);
    end
    redirect = 1'b1; redirect_pc = 4'd0;
    tick();
    redirect = 1'b0;
    n_tests++; if (fetch_halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 4'd0) begin
      n_fail++; $display("FAIL halt_resume: got halted=%b req=%b addr=%0d expected halted=0 req=1 addr=0", fetch_halted, imem_req, imem_addr);
    end
`else
    n_tests++; if (fetch_halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 4'd5) begin
      n_fail++; $display("FAIL nohalt_continue: got halted=%b req=%b addr=%0d expected halted=0 req=1 addr=5", fetch_halted, imem_req, imem_addr);
    end
`endif
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = exp_mem(i);
    lat         = 0;
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 4'd0;
    id_ready    = 1'b0;
    #2;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_discard();
    test_redirect_ack_full();
    test_wrap();
    test_zero_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end that sits directly upstream of the decode stage of the 4-stage processor. It owns the fetch PC and issues single-outstanding requests to instruction memory over a req/ack handshake. Returned 16-bit instructions are buffered in a small prefetch FIFO and presented to decode with a valid/ready handshake. A redirect input flushes the queue and restarts fetch at a new PC.

## Interface
- `PC_W`, 4, fetch address width; PC wraps modulo 2^PC_W
- `INSTR_W`, 16, instruction width: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2/imm
- `DEPTH`, 4, prefetch FIFO entries (power of two, ≥2)

- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted at 0)
- `imem_req`  out  1  fetch request, registered
- `imem_addr`  out  PC_W  fetch address; stable while `imem_req`=1
- `imem_ack`  in  1  memory returns data; sampled only when `imem_req`=1
- `imem_rdata`  in  INSTR_W  instruction data, valid with `imem_ack`
- `redirect`  in  1  flush queue and restart fetch (one-cycle pulse)
- `redirect_pc`  in  PC_W  new fetch PC, valid with `redirect`
- `id_valid`  out  1  FIFO head is valid
- `id_ready`  in  1  decode accepts the head
- `id_instr`  out  INSTR_W  FIFO head instruction
- `id_pc`  out  PC_W  PC of the FIFO head
- `queue_count`  out  clog2(DEPTH)+1  occupied entries
- `fetch_halted`  out  1  fetch stopped by halt encoding (see Configuration)

## Operation
- Reset values: `imem_req`=0, `imem_addr`=0, fetch PC=0, `id_valid`=0, `id_instr`=0, `id_pc`=0, `queue_count`=0, `fetch_halted`=0, FSM=IDLE. Every FIFO entry is cleared.
- FSM states and transitions:
  - IDLE: if not halted and `queue_count`<DEPTH, go to REQ next cycle.
  - REQ: hold `imem_req`=1 and `imem_addr`=fetch PC until ack.
    - On `imem_ack`, enqueue {`imem_rdata`, fetch PC} and increment fetch PC.
    - Stay in REQ with the new address if the post-update count (count+1−dequeue) is below DEPTH and fetch is not halting.
    - Otherwise return to IDLE.
  - DISCARD: a redirect arrived while a request was outstanding without ack. Keep `imem_req`=1 with the old address until ack, drop the returned data, then go to REQ at the redirected PC.
- At most one request is outstanding. The FIFO can never overflow, because issue requires count<DEPTH.
- Dequeue happens when `id_valid`&&`id_ready`. The head advances, and the next entry is visible in the following cycle.
- Redirect has priority over enqueue and dequeue in the same cycle:
  - count becomes 0, `id_valid`=0 next cycle, fetch PC becomes `redirect_pc`, and halt is cleared.
  - If `imem_ack` coincides with `redirect`, the data is dropped and the next state is REQ with `redirect_pc`.
  - If a request is outstanding and unacked, go to DISCARD. Otherwise go to REQ.
- Enqueue and dequeue in the same cycle leave the count unchanged. This is legal when the FIFO is full: the dequeue frees the slot.
- An asynchronous reset mid-request abandons the request immediately. Instruction memory must tolerate `imem_req` dropping without ack.

## Timing
- Reset release to first `imem_req`: 1 cycle (IDLE→REQ). Address is 0.
- `imem_ack` in cycle N → instruction on `id_instr`/`id_valid` in cycle N+1, provided the FIFO was empty.
- With a zero-wait memory (ack in the same cycle as req) and decode always ready, throughput is 1 instruction per cycle.
- `redirect` in cycle N → `id_valid`=0 in N+1. With no outstanding request, the first new `imem_req` is in N+1 at `redirect_pc`.
- Fetch PC wraps from 2^PC_W−1 to 0 with no stall.

## Configuration
- `FETCH_ZERO_HALT_EN` defined:
  - An instruction equal to all zeros (the NOP/terminator encoding) is enqueued normally.
  - Fetch then stops: FSM goes to IDLE and `fetch_halted`=1 from the next cycle.
  - Fetch stays stopped until `redirect` or reset.
- `FETCH_ZERO_HALT_EN` not defined: zero instructions are ordinary, and `fetch_halted` is tied to 0.

## Test plan
- Zero-wait memory returns 0x1123, 0x2412, 0x3502, 0x4651 at addresses 0–3, with `id_ready`=1 → `id_instr` shows those values on 4 consecutive cycles, and `id_pc` shows 0,1,2,3.
- `id_ready`=0 with zero-wait memory → exactly 4 requests (addresses 0–3), `queue_count`=4, `imem_req`=0. Raising `id_ready` → requests resume at address 4, one cycle after the first dequeue.
- Memory acks 3 cycles after req; `redirect`=1 with `redirect_pc`=9 in the second wait cycle → the ack'd data is dropped, and the next request is address 9. The first `id_pc` after the redirect is 9.
- `redirect` in the same cycle as `imem_ack` with a full FIFO → `queue_count`=0 next cycle, and `id_valid` stays 0 until data from `redirect_pc` returns.
- Fetch from address 14 with PC_W=4 → addresses 14, 15, 0, 1, and `id_pc` wraps correctly.
- With `FETCH_ZERO_HALT_EN`, memory returns 0x0000 at address 4 → the entry is delivered, there are no further requests, and `fetch_halted`=1. Then `redirect_pc`=0 → `fetch_halted`=0 and fetch resumes at 0. Without the macro, fetch continues to address 5.
